// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment patterns, converter states and widths for the scan controller
package sevenseg_pkg;
    localparam int BIN_W      = 14;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam logic [3:0] DASH_CODE = 4'hF;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;
endpackage

// File: rtl/seg_lut.sv
// seg_lut: 4-bit digit code to abcdefg pattern, non-decimal codes show a dash
module seg_lut
    import sevenseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: binary-to-BCD converter feeding a 4-digit multiplexed common-anode display
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int DWELL = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             blank_lz,
    output logic             ready,
    output logic             ovf,
    output logic [6:0]       seg,
    output logic [3:0]       an
);
    localparam int DW = $clog2(DWELL);

    conv_state_e state_q, state_d;
    logic [BIN_W-1:0] val_q, val_d, sh_q, sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [3:0] cnt_q, cnt_d;
    logic blz_q, blz_d, ready_q, ready_d, ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0][3:0] code_q, code_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0] idx_q, idx_d;
    logic [6:0] seg_q, seg_d, lut_seg;
    logic [3:0] an_q, an_d;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        blz_d   = blz_q;
        ovf_d   = ovf_q;
        code_d  = code_q;
        blank_d = blank_q;
        adj     = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        if (state_q == IDLE && load) begin
            state_d = SHIFT;
            val_d   = bin_in;
            sh_d    = bin_in;
            blz_d   = blank_lz;
            bcd_d   = '0;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d         = cnt_q + 4'd1;
            state_d       = cnt_q == 4'(BIN_W - 1) ? COMMIT : SHIFT;
        end else if (state_q == COMMIT) begin
            state_d = IDLE;
            ovf_d   = val_q > 14'd9999;
            // a digit is leading-zero when it and everything above it is zero
            for (int i = 0; i < NUM_DIGITS; i++) begin
                code_d[i]  = ovf_d ? DASH_CODE : bcd_q[4*i +: 4];
                blank_d[i] = !ovf_d && blz_q && i != 0 && (bcd_q >> (4*i)) == '0;
            end
        end
        ready_d = state_d == IDLE;
    end

    seg_lut u_lut (.code(code_q[idx_q]), .seg(lut_seg));

    always_comb begin
        dwell_d = dwell_q == DW'(DWELL - 1) ? '0 : dwell_q + 1'b1;
        idx_d   = dwell_q == DW'(DWELL - 1) ? idx_q + 2'd1 : idx_q;
        seg_d   = blank_q[idx_q] ? SEG_BLANK : lut_seg;
        an_d    = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            blz_q   <= 1'b0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            code_q  <= '0;
            blank_q <= '1;
            dwell_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            blz_q   <= blz_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
            blank_q <= blank_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign ready = ready_q;
    assign ovf   = ovf_q;
    assign seg   = seg_q;
    assign an    = an_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed scoreboard bench for the 7-segment scan controller
module tb_sevenseg_scan_ctrl;
    logic clk, rst_n, load, blank_lz, ready, ovf;
    logic [13:0] bin_in;
    logic [6:0] seg;
    logic [3:0] an;
    int n_chk = 0, n_fail = 0, cnt;

    typedef struct packed {
        logic [3:0][6:0] segs;
        logic ovf;
    } exp_t;
    exp_t sb[$];

    sevenseg_scan_ctrl #(.DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in), .blank_lz(blank_lz),
        .ready(ready), .ovf(ovf), .seg(seg), .an(an)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "global time limit expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] exp_an(input int i);
        logic [3:0] r;
        r = 4'b0001 << i;
        return ~r;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic exp_t model(input int v, input logic b);
        exp_t e;
        int p = 1;
        e.ovf = v > 9999;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999) e.segs[i] = 7'b0000001;
            else if (b && i > 0 && v < p) e.segs[i] = 7'b0000000;
            else e.segs[i] = pat((v / p) % 10);
            p = p * 10;
        end
        return e;
    endfunction

    task automatic wait_ready_count(output int c);
        c = 0;
        while (ready !== 1'b1 && c < 40) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic check_display();
        exp_t e;
        int k;
        @(negedge clk);
        e = sb.pop_front();
        chk("ovf", ovf, e.ovf);
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (an !== exp_an(i) && k < 20) begin
                k++;
                @(negedge clk);
            end
            chk("digit_found", an, exp_an(i));
            chk($sformatf("seg_digit%0d", i), seg, e.segs[i]);
        end
    endtask

    task automatic do_load(input int v, input logic b);
        sb.push_back(model(v, b));
        load = 1; bin_in = 14'(v); blank_lz = b;
        @(negedge clk);
        load = 0; bin_in = 14'($urandom); blank_lz = ~b;
        wait_ready_count(cnt);
        chk("ready_low_cycles", cnt, 15);
        check_display();
    endtask

    initial begin
        rst_n = 0; load = 0; bin_in = 0; blank_lz = 0;
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b0);
        chk("rst_ready", ready, 1);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("scan_an", an, exp_an(c / 4));
            chk("scan_seg_blank", seg, 7'b0);
        end
        do_load(1234, 0);
        do_load(7, 1);
        do_load(0, 1);
        do_load(10000, 0);
        do_load(9999, 0);
        do_load(16383, 1);
        do_load(305, 1);
        // request while busy must be dropped
        sb.push_back(model(1234, 0));
        load = 1; bin_in = 14'd1234; blank_lz = 0;
        @(negedge clk);
        load = 0;
        repeat (3) @(negedge clk);
        load = 1; bin_in = 14'd5555;
        @(negedge clk);
        load = 0;
        wait_ready_count(cnt);
        chk("busy_ready_low", cnt, 11);
        check_display();
        chk("no_queued_load", ready, 1);
        // load held high across the conversion is taken at T16
        sb.push_back(model(5555, 0));
        load = 1; bin_in = 14'd1234; blank_lz = 0;
        @(negedge clk);
        bin_in = 14'd5555;
        wait_ready_count(cnt);
        chk("held_first_low", cnt, 15);
        @(negedge clk);
        chk("held_accept_t16", ready, 0);
        load = 0; bin_in = 14'($urandom);
        wait_ready_count(cnt);
        chk("held_second_low", cnt, 15);
        check_display();
        // reset during conversion
        load = 1; bin_in = 14'd4321; blank_lz = 0;
        @(negedge clk);
        load = 0;
        repeat (7) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        chk("midrst_an", an, 4'b1111);
        chk("midrst_seg", seg, 7'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("post_rst_blank", seg, 7'b0);
        end
        chk("post_rst_ready", ready, 1);
        chk("post_rst_ovf", ovf, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Multiplexed display controller for a 4-digit common-anode 7-segment display. Accepts a 14-bit binary value through a valid/ready handshake and converts it to BCD with a sequential shift-and-add-3 engine. It then time-multiplexes the four digits onto one shared segment bus with an active-low digit enable per digit. It sits between the LC-3 output register and the board display pins.

## Interface
- `DWELL`, default 1000: cycles each digit is driven per scan slot; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `load`  in  1  request to display `bin_in`.
- `bin_in`  in  14  unsigned value, 0..16383.
- `blank_lz`  in  1  leading-zero blanking enable; sampled with `bin_in`.
- `ready`  out  1  high when a new value can be accepted.
- `ovf`  out  1  latched value was > 9999.
- `seg`  out  7  segments abcdefg; 1 = lit.
- `an`  out  4  digit enables, active-low; `an[0]` = least significant digit.

## Operation
- Reset values: `ready`=1, `ovf`=0, `seg`=7'b0000000, `an`=4'b1111. All four display slots are blank. Scan index = 0 and dwell counter = 0.
- Handshake: a value is accepted on a rising edge with `load`=1 and `ready`=1. That edge captures `bin_in` and `blank_lz`. `load` while `ready`=0 is ignored and is not queued.
- Converter FSM has three states:
  - IDLE: `ready`=1. Moves to SHIFT on accept and clears the 16-bit BCD scratch.
  - SHIFT: exactly 14 cycles. Each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left 1. After the 14th cycle, moves to COMMIT.
  - COMMIT: 1 cycle, then returns to IDLE. Writes the display slots, `ovf` and the blank flags atomically.
- Commit rules:
  - If the value > 9999: `ovf`=1 and all slots show the dash 7'b0000001. The BCD result is discarded.
  - Otherwise `ovf`=0. With `blank_lz`=1, each zero digit above the most significant nonzero digit is blank (7'b0000000). Digit 0 is never blanked, so a value of 0 shows "0".
- Segment map (lit=1):
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1110011
  - Any other code: 0000001.
- Scanner runs continuously and independently of the converter:
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1 it wraps to 0, and the scan index advances 0→1→2→3→0.
- `an` is one-hot-low on the scan index. `seg` is the decoded pattern of the indexed slot, or 0000000 for a blank slot.

## Timing
- Accept at edge T0. SHIFT occupies edges T1..T14 and COMMIT is edge T15. `ready` is low for cycles following T0..T14 and high again after T15, so a new accept is possible at T16.
- `seg` and `an` are registered: they reflect the scan index and slot contents of the previous cycle (1-cycle latency). New digits appear on `seg` the cycle after COMMIT.
- Digit switch: `an` and `seg` change together in the same cycle. There is no ghosting interval.
- Simultaneous COMMIT and scan advance: the new index drives the new slot data.
- Reset mid-conversion: the FSM goes to IDLE, the scratch is discarded, and the display returns to blank. Reset has priority over `load`.
- `bin_in` and `blank_lz` may change freely after accept. The captured copies are used.

## Structure
- Package `sevenseg_pkg` holds:
  - The 7-bit segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK).
  - The converter state enum {IDLE, SHIFT, COMMIT}.
  - The constants BIN_W=14 and NUM_DIGITS=4.
- Sub-module `seg_lut`: purely combinational 4-bit code → 7-bit pattern. It is instantiated once, on the scan path, between the slot mux and the output register.

## Test plan
- Reset held 3 cycles → `an`=1111, `seg`=0000000, `ready`=1. After release with DWELL=4, `an` steps 1110, 1101, 1011, 0111 every 4 cycles and `seg` stays 0000000.
- Load 1234, `blank_lz`=0 → `ready` low exactly 15 cycles. Then digits 0..3 show 0110011, 1111001, 1101101, 0110000, and `ovf`=0.
- Load 7, `blank_lz`=1 → digit 0 = 1110000 and digits 1..3 = 0000000. Load 0, `blank_lz`=1 → digit 0 = 1111110 and the rest are blank.
- Load 10000 → `ovf`=1 and all four digits = 0000001. Then load 9999 → `ovf`=0 and all digits = 1110011.
- Load 1234, then pulse `load` with 5555 during SHIFT → the second request is ignored and 1234 is displayed. A `load` of 5555 held until `ready` rises is accepted at T16.
- Load 4321, then assert `rst_n`=0 at T8 → after release the display is blank, `ready`=1, and no 4321 digits ever appear.
